// File: rtl/dlfloat_mac_sequencer.sv
// dlfloat_mac_sequencer: loads A/B/C operand words, issues the MAC core and streams the 16-bit result bytewise
module dlfloat_mac_sequencer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  input  logic [7:0]  uio_in,
  input  logic [7:0]  ui_in,
  input  logic        acc_mode,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [15:0] mac_c,
  output logic        mac_start,
  input  logic        mac_done,
  input  logic [15:0] mac_result,
  output logic [7:0]  uo_out,
  output logic        res_valid,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYC);
  localparam logic [2:0] S_LD_A   = 3'd0;
  localparam logic [2:0] S_LD_B   = 3'd1;
  localparam logic [2:0] S_LD_C   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_OUT_HI = 3'd5;
  localparam logic [2:0] S_OUT_LO = 3'd6;
  logic [2:0]    r_state;
  logic [15:0]   r_a, r_b, r_c, r_acc;
  logic [7:0]    r_uo;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [15:0]   w_word;
  logic [CW-1:0] w_cnt_nx;
  assign w_word    = {uio_in, ui_in};
  assign w_cnt_nx  = r_cnt + 1'b1;
  assign mac_a     = r_a;
  assign mac_b     = r_b;
  assign mac_c     = r_c;
  assign uo_out    = r_uo;
  assign err       = r_err;
  assign busy      = r_state != S_LD_A;
  assign mac_start = ena & (r_state == S_ISSUE);
  assign res_valid = ena & ((r_state == S_OUT_HI) | (r_state == S_OUT_LO));
  // Sequencer: a completion in the same cycle the wait budget expires takes priority over the timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_LD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_uo    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (ena) begin
      case (r_state)
        S_LD_A: if (in_valid) begin
          r_a     <= w_word;
          r_state <= S_LD_B;
        end
        S_LD_B: if (in_valid) begin
          r_b     <= w_word;
          r_c     <= acc_mode ? r_acc : r_c;
          r_state <= acc_mode ? S_ISSUE : S_LD_C;
        end
        S_LD_C: if (in_valid) begin
          r_c     <= w_word;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (mac_done) begin
          r_acc   <= mac_result;
          r_uo    <= mac_result[15:8];
          r_state <= S_OUT_HI;
        end else if (w_cnt_nx == TO) begin
          r_err   <= 1'b1;
          r_state <= S_LD_A;
        end else r_cnt <= w_cnt_nx;
        S_OUT_HI: begin
          r_uo    <= r_acc[7:0];
          r_state <= S_OUT_LO;
        end
        default: r_state <= S_LD_A;
      endcase
    end
endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// tb_dlfloat_mac_sequencer: randomized and directed bench with a transaction-level model and a stub MAC core
module tb_dlfloat_mac_sequencer;
  logic        clk = 0, rst_n = 0, ena = 0, in_valid = 0, acc_mode = 0, mac_done = 0;
  logic [7:0]  uio_in = 0, ui_in = 0;
  logic [15:0] mac_result = 0;
  logic [15:0] mac_a, mac_b, mac_c;
  logic        mac_start, res_valid, busy, err;
  logic [7:0]  uo_out;
  int          total = 0, passed = 0;
  logic [15:0] m_acc = 0;
  logic        m_err = 0;
  logic [7:0]  m_last = 0;
  logic [47:0] q_iss[$];
  logic [7:0]  q_byte[$];
  logic [47:0] cmp_e;
  int          st_d = 0, st_cnt = 0;
  bit          st_seen = 0;
  logic [15:0] st_res = 0;

  dlfloat_mac_sequencer #(.TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .uio_in(uio_in), .ui_in(ui_in),
    .acc_mode(acc_mode), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_start(mac_start),
    .mac_done(mac_done), .mac_result(mac_result), .uo_out(uo_out), .res_valid(res_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Stub MAC: done pulses in the d-th WAIT cycle after a start; d=0 never answers
  always @(posedge clk) begin
    #1;
    mac_done = 0;
    if (st_seen) begin st_seen = 0; st_cnt = st_d; end
    if (st_cnt > 0) begin st_cnt--; if (st_cnt == 0) mac_done = 1; end
    mac_result = mac_done ? st_res : 16'($urandom);
  end

  // Per-cycle compare: every start must match the expected operand triple, every result byte the expected stream
  always @(negedge clk) if (rst_n) begin
    if (mac_start) begin
      st_seen = 1;
      if (q_iss.size() == 0) begin total++; $display("FAIL start: unexpected mac_start"); end
      else begin
        cmp_e = q_iss.pop_front();
        chk("mac_a", mac_a, cmp_e[47:32]);
        chk("mac_b", mac_b, cmp_e[31:16]);
        chk("mac_c", mac_c, cmp_e[15:0]);
      end
    end
    if (res_valid) begin
      if (q_byte.size() == 0) begin total++; $display("FAIL res_valid: unexpected byte %h", uo_out); end
      else begin m_last = q_byte.pop_front(); chk("uo_out", {8'h0, uo_out}, {8'h0, m_last}); end
    end else chk("uo_hold", {8'h0, uo_out}, {8'h0, m_last});
  end

  // One operation: g=0 no gaps, 1 gap before each later word, 2 random gaps; frz freezes 4 WAIT cycles; ra>0 resets mid-WAIT
  task automatic op(input logic [15:0] a, b, c, input bit am, input int d, input logic [15:0] r,
                    input int g, input bit frz, input int ra);
    logic [15:0] w[3];
    int n;
    bit tmo;
    w = '{a, b, c};
    n = am ? 2 : 3;
    tmo = (d == 0) || (d - (frz ? 4 : 0) > 15);
    q_iss.push_back({a, b, am ? m_acc : c});
    if (!tmo) begin q_byte.push_back(r[15:8]); q_byte.push_back(r[7:0]); m_acc = r; end
    else m_err = 1;
    st_d = d;
    st_res = r;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (g == 1 || (g == 2 && $urandom_range(1) == 1))) begin
        in_valid = 0; {uio_in, ui_in} = 16'($urandom); acc_mode = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1; {uio_in, ui_in} = w[i]; acc_mode = (i == 1) ? am : 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0; acc_mode = 1'($urandom); {uio_in, ui_in} = 16'($urandom);
    @(negedge clk);
    chk("start_latency", {15'h0, mac_start}, 16'h1);
    chk("busy_issue", {15'h0, busy}, 16'h1);
    if (ra > 0) begin
      repeat (ra) @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("rst_a", mac_a, 0); chk("rst_b", mac_b, 0); chk("rst_c", mac_c, 0);
      chk("rst_uo", {8'h0, uo_out}, 0);
      chk("rst_flags", {12'h0, mac_start, res_valid, busy, err}, 0);
      q_byte.delete(); q_iss.delete();
      m_acc = 0; m_err = 0; m_last = 0;
      @(negedge clk) rst_n = 1;
      return;
    end
    if (frz) begin
      repeat (2) @(posedge clk);
      #1 ena = 0;
      repeat (4) @(posedge clk);
      chk("frz_busy", {15'h0, busy}, 16'h1);
      #1 ena = 1;
    end
    for (int k = 0; k < 80 && busy; k++) @(negedge clk);
    chk("done_busy", {15'h0, busy}, 16'h0);
    chk("err", {15'h0, err}, {15'h0, m_err});
    chk("iss_drained", 16'(q_iss.size()), 0);
    chk("bytes_drained", 16'(q_byte.size()), 0);
  endtask

  initial begin
    int d;
    bit frz;
    ena = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", mac_a, 0); chk("reset_b", mac_b, 0); chk("reset_c", mac_c, 0);
    chk("reset_uo", {8'h0, uo_out}, 0);
    chk("reset_flags", {12'h0, mac_start, res_valid, busy, err}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // normal op
    op(16'h3EA3, 16'h4073, 16'h3EA3, 0, 3, 16'h5A1C, 0, 0, 0);
    chk("t1_a", mac_a, 16'h3EA3); chk("t1_b", mac_b, 16'h4073); chk("t1_c", mac_c, 16'h3EA3);
    chk("t1_uo", {8'h0, uo_out}, 16'h001C);
    // accumulate: C is the previous result
    op(16'hBEC7, 16'h40AB, 16'h0000, 1, 4, 16'h5B20, 0, 0, 0);
    chk("t2_c", mac_c, 16'h5A1C); chk("t2_uo", {8'h0, uo_out}, 16'h0020);
    // gaps plus a 4-cycle freeze; 17 real WAIT cycles but only 13 counted
    op(16'h1234, 16'h5678, 16'h9ABC, 0, 17, 16'h3C1C, 1, 1, 0);
    chk("t3_a", mac_a, 16'h1234); chk("t3_b", mac_b, 16'h5678); chk("t3_c", mac_c, 16'h9ABC);
    chk("t3_err", {15'h0, err}, 16'h0);
    // timeout, then a normal op with err staying set
    op(16'h1111, 16'h2222, 16'h3333, 0, 0, 16'hFFFF, 0, 0, 0);
    chk("t4_err", {15'h0, err}, 16'h1); chk("t4_busy", {15'h0, busy}, 16'h0);
    chk("t4_uo", {8'h0, uo_out}, 16'h001C);
    op(16'h2020, 16'h3030, 16'h4040, 0, 2, 16'h4E00, 0, 0, 0);
    chk("t4_err_sticky", {15'h0, err}, 16'h1);
    // reset mid-WAIT, late stub done must be ignored
    op(16'h5555, 16'h6666, 16'h7777, 0, 10, 16'hABCD, 0, 0, 4);
    repeat (14) @(negedge clk);
    chk("t6_busy", {15'h0, busy}, 16'h0); chk("t6_err", {15'h0, err}, 16'h0);
    chk("t6_a", mac_a, 16'h0000);
    // first accumulate after reset uses C = +0
    op(16'h4000, 16'h4000, 16'hFFFF, 1, 2, 16'h4400, 0, 0, 0);
    chk("acc_zero_c", mac_c, 16'h0000);
    // done on exactly the 15th WAIT cycle wins over the timeout
    op(16'h0A0A, 16'h0B0B, 16'h0C0C, 0, 15, 16'h7E81, 0, 0, 0);
    chk("t5_err", {15'h0, err}, 16'h0); chk("t5_uo", {8'h0, uo_out}, 16'h0081);
    // randomized back-to-back traffic
    for (int t = 0; t < 40; t++) begin
      d = $urandom_range(0, 20);
      frz = ($urandom_range(0, 3) == 0) && (d == 0 || d >= 7);
      op(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), d, 16'($urandom), 2, frz, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
